// File: rtl/ha_pkg.sv
// ============================================================================
//  Module : ha_pkg
//  Brief  : Shared width default and per-lane result type for the half adder.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package ha_pkg;

  localparam int HA_DEFAULT_WIDTH = 1;

  // Lane result: {cout, s} reads directly as the 2-bit sum a + b.
  typedef struct packed {
    logic cout;
    logic s;
  } ha_res_t;

endpackage

`default_nettype wire

// File: rtl/ha_cell.sv
// ============================================================================
//  Module : ha_cell
//  Brief  : Purely combinational 1-bit half adder (a, b -> s, cout).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic cout
);

  assign s    = a ^ b;
  assign cout = a & b;

endmodule

`default_nettype wire

// File: rtl/half_adder.sv
// ============================================================================
//  Module : half_adder
//  Brief  : Registered lane-parallel half adder with valid qualifier and
//           OR-reduced carry flag; one cycle of latency, no inter-lane carry.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module half_adder
  import ha_pkg::*;
#(
  parameter int WIDTH = HA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Cout,
  output logic             carry_any
);

  ha_res_t [WIDTH-1:0] lane_res;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      ha_cell u_cell (
        .a    (A[i]),
        .b    (B[i]),
        .s    (lane_res[i].s),
        .cout (lane_res[i].cout)
      );
    end
  endgenerate

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] carry_w;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic [WIDTH-1:0] cout_d, cout_q;
  logic             carry_any_d, carry_any_q;

  always_comb begin
    sum_w   = '0;
    carry_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_w[i]   = lane_res[i].s;
      carry_w[i] = lane_res[i].cout;
    end
  end

  // Data registers only load on a valid input so X on idle operands never
  // reaches the outputs.
  always_comb begin
    valid_d     = in_valid;
    s_d         = s_q;
    cout_d      = cout_q;
    carry_any_d = carry_any_q;
    if (in_valid) begin
      s_d         = sum_w;
      cout_d      = carry_w;
      carry_any_d = |carry_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      s_q         <= '0;
      cout_q      <= '0;
      carry_any_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      carry_any_q <= carry_any_d;
    end
  end

  assign out_valid = valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign carry_any = carry_any_q;

endmodule

`default_nettype wire

// File: tb/tb_half_adder.sv
// ============================================================================
//  Module : tb_half_adder
//  Brief  : Self-checking bench for half_adder at WIDTH=1 and WIDTH=8.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_half_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [7:0] a8 = '0, b8 = '0;

  logic       ov1, any1, ov8, any8;
  logic [0:0] s1, c1;
  logic [7:0] s8, c8;

  half_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a1), .B(b1),
    .out_valid(ov1), .S(s1), .Cout(c1), .carry_any(any1)
  );

  half_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a8), .B(b8),
    .out_valid(ov8), .S(s8), .Cout(c8), .carry_any(any8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each lane is an integer addition; bit 0 is the sum, bit 1 the carry.
  function automatic logic [15:0] lane_add(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    int t;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      t = (a[i] ? 1 : 0) + (b[i] ? 1 : 0);
      r[i]     = (t % 2) == 1;
      r[8 + i] = (t / 2) == 1;
    end
    return r;
  endfunction

  logic       m_on = 1'b0;
  logic       m_v;
  logic [7:0] m_s8, m_c8;
  logic       m_s1, m_c1;
  logic [15:0] m_tmp;

  always @(posedge clk) begin
    if (rst) begin
      m_on <= 1'b1;
      m_v  <= 1'b0;
      m_s8 <= '0; m_c8 <= '0;
      m_s1 <= 1'b0; m_c1 <= 1'b0;
    end else if (in_valid) begin
      m_tmp = lane_add(a8, b8);
      m_v  <= 1'b1;
      m_s8 <= m_tmp[7:0];
      m_c8 <= m_tmp[15:8];
      m_tmp = lane_add({7'b0, a1}, {7'b0, b1});
      m_s1 <= m_tmp[0];
      m_c1 <= m_tmp[8];
    end else begin
      m_v <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("model_ov1",  ov1,  m_v);
      check("model_s1",   s1,   m_s1);
      check("model_c1",   c1,   m_c1);
      check("model_any1", any1, m_c1);
      check("model_ov8",  ov8,  m_v);
      check("model_s8",   s8,   m_s8);
      check("model_c8",   c8,   m_c8);
      check("model_any8", any8, m_c8 != 8'h00);
      if (ov8) check("excl8", s8 & c8, 32'h0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic exp_s_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic exp_c_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0] k2;

  initial begin
    // Power-up with reset held: outputs stay cleared whatever the inputs do.
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1; in_valid = 1'b1;
      a1 = 1'b1; b1 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      cyc();
      check("pwr_ov8", ov8, 0);
      check("pwr_s8",  s8,  0);
      check("pwr_c8",  c8,  0);
      check("pwr_any8", any8, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    check("post_rst_ov1", ov1, 0);
    check("post_rst_ov8", ov8, 0);
    cyc();

    // Exhaustive single-lane truth table, back to back.
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      k2 = 2'(k);
      a1 = k2[1]; b1 = k2[0];
      a8 = {8{k2[1]}}; b8 = {8{k2[0]}};
      cyc();
      check("tt_ov1", ov1, 1);
      check("tt_s1",  s1,  exp_s_tab[k]);
      check("tt_c1",  c1,  exp_c_tab[k]);
    end

    // Hold: idle inputs toggle, registered data stays at the 1+1 result.
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a1 = ~a1; b1 = 1'(i); a8 = ~a8; b8 = 8'($urandom);
      cyc();
      check("hold_ov1",  ov1,  0);
      check("hold_s1",   s1,   0);
      check("hold_c1",   c1,   1);
      check("hold_any1", any1, 1);
    end

    // Reset mid-stream discards the coincident valid input.
    rst = 1'b1; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    cyc();
    check("mid_rst_ov1",  ov1,  0);
    check("mid_rst_s1",   s1,   0);
    check("mid_rst_c1",   c1,   0);
    check("mid_rst_any8", any8, 0);
    rst = 1'b0; a1 = 1'b1; b1 = 1'b0;
    cyc();
    check("after_rst_ov1", ov1, 1);
    check("after_rst_s1",  s1,  1);
    check("after_rst_c1",  c1,  0);

    // Multi-lane directed vectors.
    a8 = 8'hF0; b8 = 8'hCC;
    cyc();
    check("ml1_s8",   s8,   32'h3C);
    check("ml1_c8",   c8,   32'hC0);
    check("ml1_any8", any8, 1);
    a8 = 8'h0F; b8 = 8'hF0;
    cyc();
    check("ml2_s8",   s8,   32'hFF);
    check("ml2_c8",   c8,   32'h00);
    check("ml2_any8", any8, 0);

    // Random traffic; the per-cycle compare covers it.
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a1 = 1'($urandom); b1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      cyc();
    end

    in_valid = 1'b0;
    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
